// File: rtl/ff_fifo_pkg.sv
// Shared helpers for the flip-flop FIFO family: explicit-wrap pointer increment
// and occupancy-counter width, reused by the single- and dual-clock variants.
package ff_fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps at depth-1 rather than relying on natural overflow.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ff_fifo_wrap_ptr.sv
// Modulo-depth pointer register for non-power-of-two storage.
// Zero latency beyond the clock edge; advances only when inc is high.
module ff_fifo_wrap_ptr
    import ff_fifo_pkg::*;
#(
    parameter  int depth = 5,
    localparam int pw    = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [pw-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= pw'(wrap_inc(int'(ptr), depth));
        end
    end

endmodule

// File: rtl/ff_fifo_any_depth.sv
// Single-clock show-ahead FIFO of arbitrary depth with occupancy, almost flags and sticky errors.
// read_data is combinational from the head; push at full is accepted only alongside a pop.
module ff_fifo_any_depth
    import ff_fifo_pkg::*;
#(
    parameter  int width            = 64,
    parameter  int depth            = 5,
    parameter  int almost_full_thr  = depth - 1,
    parameter  int almost_empty_thr = 1,
    localparam int cw               = cnt_width(depth),
    localparam int pw               = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [cw-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    if (depth < 2) begin : g_chk_depth
        $error("ff_fifo_any_depth: depth must be >= 2");
    end
    if (almost_full_thr < 1 || almost_full_thr > depth) begin : g_chk_af
        $error("ff_fifo_any_depth: almost_full_thr out of range 1..depth");
    end
    if (almost_empty_thr < 0 || almost_empty_thr >= depth) begin : g_chk_ae
        $error("ff_fifo_any_depth: almost_empty_thr out of range 0..depth-1");
    end

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign push_ok = push & (~full | pop_ok);

    ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= write_data;
        end
    end

    assign read_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
            if (push & full & ~pop) overflow  <= 1'b1;
            if (pop & empty)        underflow <= 1'b1;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == cw'(depth));
    assign almost_full  = (count >= cw'(almost_full_thr));
    assign almost_empty = (count <= cw'(almost_empty_thr));

endmodule

// File: tb/tb_ff_fifo_any_depth.sv
// Directed and random stimulus for ff_fifo_any_depth (width 8, depth 5) checked against a queue model.
module tb_ff_fifo_any_depth;

    localparam int W     = 8;
    localparam int D     = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic         clk;
    logic         rst_n;
    logic         push;
    logic         pop;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    ff_fifo_any_depth #(
        .width            (W),
        .depth            (D),
        .almost_full_thr  (AF),
        .almost_empty_thr (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    logic         m_ov;
    logic         m_un;
    int           checks;
    int           errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},        32'(count),        32'(n));
        check({tag, ".empty"},        32'(empty),        32'(n == 0));
        check({tag, ".full"},         32'(full),         32'(n == D));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ov));
        check({tag, ".underflow"},    32'(underflow),    32'(m_un));
        if (n > 0) check({tag, ".read_data"}, 32'(read_data), 32'(q[0]));
    endtask

    // Called just after a falling edge; applies one cycle and checks the result.
    task automatic cycle(input string tag, input logic p, input logic o, input logic [W-1:0] d);
        bit was_full, was_empty, pop_ok, push_ok;
        push = p;
        pop = o;
        write_data = d;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        pop_ok  = o && !was_empty;
        push_ok = p && (!was_full || pop_ok);
        if (o && was_empty)        m_un = 1'b1;
        if (p && was_full && !o)   m_ov = 1'b1;
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(d);
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        check_all(tag);
    endtask

    // Asserts reset between edges and confirms it acts without a clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        check({tag, ".async_count"}, 32'(count), 32'd0);
        check({tag, ".async_empty"}, 32'(empty), 32'd1);
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ov = 1'b0;
        m_un = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        write_data = '0;
        rst_n = 1'b0;

        // 1: reset state, pop on empty
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");
        cycle("pop_empty", 1'b0, 1'b1, 8'h00);
        check("pop_empty.underflow_set", 32'(underflow), 32'd1);

        // 2: fill and wrap
        do_reset("t2");
        for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 1'b0, 8'(8'h11 + i));
        check("fill.full", 32'(full), 32'd1);
        for (int i = 0; i < 3; i++) cycle("pop3", 1'b0, 1'b1, 8'h00);
        check("pop3.head", 32'(read_data), 32'h14);
        for (int i = 0; i < 3; i++) cycle("wrap", 1'b1, 1'b0, 8'(8'h16 + i));
        for (int i = 0; i < 5; i++) begin
            check("drain.order", 32'(read_data), 32'(8'h14 + i));
            cycle("drain", 1'b0, 1'b1, 8'h00);
        end
        check("drain.empty", 32'(empty), 32'd1);

        // 3: full with simultaneous push/pop
        do_reset("t3");
        for (int i = 0; i < 5; i++) cycle("fill3", 1'b1, 1'b0, 8'(8'h21 + i));
        cycle("pp_full", 1'b1, 1'b1, 8'h30);
        check("pp_full.head", 32'(read_data), 32'h22);
        check("pp_full.count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) cycle("drain3", 1'b0, 1'b1, 8'h00);

        // 4: overflow is sticky and the rejected word never appears
        for (int i = 0; i < 5; i++) cycle("fill4", 1'b1, 1'b0, 8'(8'h31 + i));
        cycle("ovf", 1'b1, 1'b0, 8'h40);
        check("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) cycle("drain4", 1'b0, 1'b1, 8'h00);
        check("ovf.hold", 32'(overflow), 32'd1);

        // 5: empty with simultaneous push/pop
        do_reset("t5");
        cycle("pp_empty", 1'b1, 1'b1, 8'h55);
        check("pp_empty.data", 32'(read_data), 32'h55);
        check("pp_empty.underflow", 32'(underflow), 32'd1);

        // 6: async reset mid-stream
        do_reset("t6a");
        for (int i = 0; i < 3; i++) cycle("fill6", 1'b1, 1'b0, 8'(8'h61 + i));
        do_reset("t6b");
        cycle("after_rst_push", 1'b1, 1'b0, 8'h66);
        check("after_rst.data", 32'(read_data), 32'h66);
        cycle("after_rst_pop", 1'b0, 1'b1, 8'h00);

        // Random traffic in phases biased towards filling, draining and balanced
        for (int i = 0; i < 900; i++) begin
            int ph;
            int pp;
            int op;
            ph = (i / 100) % 3;
            pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            op = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #2;
                do_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(0, 99) < pp),
                      ($urandom_range(0, 99) < op),
                      8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
